vga_grid_renderer: RTL and testbench

- Next-generation memory-view VGA renderer with its own parametrised H/V timing counters.
- Issues word-read addresses to a fixed-latency display memory and aligns sync and coordinates to the returned data through a pipeline.
- Draws the bit grid with pixel/byte/word borders, an overlay region, and selectable test modes.
- Sits between the display memory read port and the VGA DAC pins.

---
 rtl/vga_grid_renderer_if.sv | 11 +
 rtl/vga_grid_renderer.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_grid_renderer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vga_grid_renderer_if.sv
// Display-memory read port between vga_grid_renderer (master) and the memory (slave).
interface vga_grid_renderer_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/vga_grid_renderer.sv
// Memory-view VGA renderer: H/V timing, word addressing, latency-aligned colour stage.
// Define CURSOR_EN to add cursor_addr and the blinking highlight of that word.
module vga_grid_renderer #(
    parameter int unsigned H_ACTIVE                = 640,
    parameter int unsigned H_FP                    = 16,
    parameter int unsigned H_SYNC                  = 96,
    parameter int unsigned H_BP                    = 48,
    parameter int unsigned V_ACTIVE                = 480,
    parameter int unsigned V_FP                    = 10,
    parameter int unsigned V_SYNC                  = 2,
    parameter int unsigned V_BP                    = 33,
    parameter int unsigned PIX_DIV                 = 2,
    parameter bit          SYNC_ACTIVE_LOW         = 1'b1,
    parameter int unsigned DATA_WIDTH              = 16,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_X = 4,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = 4,
    parameter int unsigned GRID_X_END              = 512,
    parameter int unsigned GRID_Y_END              = 384,
    parameter int unsigned ADDR_WIDTH              = 10,
    parameter int unsigned READ_LATENCY            = 2
`ifdef CURSOR_EN
    ,
    parameter int unsigned BLINK_FRAMES            = 30
`endif
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic [1:0]            mode,
    vga_grid_renderer_if.master   mem,
    input  logic                  overlay_request,
    input  logic [7:0]            overlay_rgb,
    output logic [9:0]            pixel_x,
    output logic [9:0]            pixel_y,
    output logic [2:0]            RED,
    output logic [2:0]            GREEN,
    output logic [1:0]            BLUE,
    output logic                  h_sync,
    output logic                  v_sync,
    output logic                  frame_start
`ifdef CURSOR_EN
    ,
    input  logic [ADDR_WIDTH-1:0] cursor_addr
`endif
);

    localparam int unsigned H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT         = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT         = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_FIRST      = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST      = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  GRID_X        = 10'(GRID_X_END);
    localparam logic [9:0]  GRID_Y        = 10'(GRID_Y_END);
    localparam int unsigned PPW           = DATA_WIDTH << BITS_PER_MEMORY_PIXEL_X;
    localparam int unsigned PPW_LOG2      = $clog2(PPW);
    localparam int unsigned WORDS_PER_ROW = GRID_X_END / PPW;
    localparam int unsigned DW_LOG2       = $clog2(DATA_WIDTH);
    localparam logic [DW_LOG2-1:0] TOP_BIT = DW_LOG2'(DATA_WIDTH - 1);
    localparam logic [9:0]  WORD_MASK     = 10'((1 << (BITS_PER_MEMORY_PIXEL_X + 4)) - 1);
    localparam logic [9:0]  BYTE_MASK     = 10'((1 << (BITS_PER_MEMORY_PIXEL_X + 3)) - 1);
    localparam logic [9:0]  PIX_X_MASK    = 10'((1 << BITS_PER_MEMORY_PIXEL_X) - 1);
    localparam logic [9:0]  PIX_Y_MASK    = 10'((1 << BITS_PER_MEMORY_PIXEL_Y) - 1);
    localparam int unsigned DIV_W         = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    typedef struct packed {
`ifdef CURSOR_EN
        logic [ADDR_WIDTH-1:0] addr;
`endif
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
    } stage_t;

    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic [9:0]            h_cnt, v_cnt, h_nxt, v_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  nxt_in_grid;
    stage_t                cur, al;
    stage_t                pipe [READ_LATENCY];
    logic [7:0]            colour_nxt;
    logic [2:0]            bar_idx;
    logic [DW_LOG2-1:0]    bit_pos;
    logic                  mem_bit, in_grid, at_origin, origin_q;

    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
        nxt_in_grid = (h_nxt < GRID_X) && (v_nxt < GRID_Y);
        addr_nxt    = ADDR_WIDTH'(32'(v_nxt >> BITS_PER_MEMORY_PIXEL_Y) * WORDS_PER_ROW
                                  + 32'(h_nxt >> PPW_LOG2));
    end

    // mem_addr is registered from the next counter value so it lines up with h_cnt/v_cnt.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            div_cnt      <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            mem.mem_addr <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            if (nxt_in_grid)
                mem.mem_addr <= addr_nxt;
        end
    end

    always_comb begin
        cur     = '0;
        cur.x   = h_cnt;
        cur.y   = v_cnt;
        cur.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        cur.hs  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        cur.vs  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
`ifdef CURSOR_EN
        cur.addr = mem.mem_addr;
`endif
    end

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= cur;
            for (int unsigned i = 1; i < READ_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign al      = pipe[READ_LATENCY-1];
    assign pixel_x = al.x;
    assign pixel_y = al.y;

`ifdef CURSOR_EN
    localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);
    logic [BF_W-1:0] frame_cnt;
    logic            blink_phase;

    // Phase flips at the counter wrap; the aligned stage is then in blanking, so no tear.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick && h_cnt == H_LAST && v_cnt == V_LAST) begin
            if (frame_cnt == BF_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        colour_nxt = '0;
        bar_idx    = 3'((32'(al.x) * 32'd8) / H_ACTIVE);
        bit_pos    = DW_LOG2'(al.x >> BITS_PER_MEMORY_PIXEL_X);
        mem_bit    = mem.mem_data[TOP_BIT - bit_pos];
        in_grid    = (al.x < GRID_X) && (al.y < GRID_Y);
        at_origin  = al.act && (al.x == '0) && (al.y == '0);
        if (al.act) begin
            case (mode)
                2'b01: colour_nxt = 8'b111_000_00;
                2'b10: colour_nxt = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {2{bar_idx[0]}}};
                default: begin
                    if (!in_grid)
                        colour_nxt = overlay_request ? overlay_rgb : 8'b000_001_00;
                    else if (mode == 2'b00 && (al.x & WORD_MASK) == '0)
                        colour_nxt = 8'b000_000_11;
                    else if (mode == 2'b00 && (al.x & BYTE_MASK) == '0)
                        colour_nxt = 8'b000_000_01;
                    else if (mode == 2'b00 && ((al.x & PIX_X_MASK) == '0 || (al.y & PIX_Y_MASK) == '0))
                        colour_nxt = 8'b111_000_00;
                    else if (mem_bit)
                        colour_nxt = 8'b111_111_11;
`ifdef CURSOR_EN
                    else if (blink_phase && al.addr == cursor_addr)
                        colour_nxt = 8'b111_111_00;
`endif
                    else
                        colour_nxt = 8'b001_001_01;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            {RED, GREEN, BLUE} <= '0;
            h_sync             <= SYNC_ACTIVE_LOW;
            v_sync             <= SYNC_ACTIVE_LOW;
            frame_start        <= 1'b0;
            origin_q           <= 1'b0;
        end else begin
            {RED, GREEN, BLUE} <= colour_nxt;
            h_sync             <= al.hs ^ SYNC_ACTIVE_LOW;
            v_sync             <= al.vs ^ SYNC_ACTIVE_LOW;
            frame_start        <= at_origin && !origin_q;
            origin_q           <= at_origin;
        end
    end

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Randomized bench for vga_grid_renderer against a cycle-count-based reference of the display.
`timescale 1ns/1ps
module tb_vga_grid_renderer;

    localparam int HA = 160, HFP = 4, HS = 12, HBP = 4;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 4;
    localparam int PD = 2, DW = 16, BPX = 2, BPY = 2;
    localparam int GX = 128, GY = 32, AW = 8, RL = 3;
    localparam bit SAL = 1'b1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int PPW = DW << BPX;
    localparam int FRAME = HT * VT * PD;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       ovr_req;
    logic [7:0] ovr_rgb;
    logic [9:0] pixel_x, pixel_y;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       h_sync, v_sync, frame_start;

    always #5 clk = ~clk;

    vga_grid_renderer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    vga_grid_renderer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIX_DIV(PD), .SYNC_ACTIVE_LOW(SAL), .DATA_WIDTH(DW),
        .BITS_PER_MEMORY_PIXEL_X(BPX), .BITS_PER_MEMORY_PIXEL_Y(BPY),
        .GRID_X_END(GX), .GRID_Y_END(GY), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
    ) dut (
        .CLK_50(clk), .RESET(rst), .mode(mode), .mem(mem_bus),
        .overlay_request(ovr_req), .overlay_rgb(ovr_rgb),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .RED(red), .GREEN(green), .BLUE(blue),
        .h_sync(h_sync), .v_sync(v_sync), .frame_start(frame_start)
    );

    // Display memory with a fixed read latency of RL cycles.
    logic [DW-1:0] mem_arr [1<<AW];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_arr[mem_bus.mem_addr];
        for (int i = 1; i < RL; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_bus.mem_data = rd_pipe[RL-1];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          j        = 0;
    int          last_word = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Screen position m CLK_50 cycles after reset release.
    function automatic void pos_of(input int m, output int h, output int v);
        int n;
        n = m / PD;
        h = n % HT;
        v = (n / HT) % VT;
    endfunction

    function automatic int word_of(input int x, input int y);
        return ((y >> BPY) * (GX / PPW) + x / PPW) % (1 << AW);
    endfunction

    function automatic logic [7:0] exp_colour(input int x, input int y, input logic [1:0] md,
                                              input logic oreq, input logic [7:0] orgb);
        logic [DW-1:0] w;
        int k, b;
        if (x >= HA || y >= VA) return 8'h00;
        if (md == 2'b01) return 8'b111_000_00;
        if (md == 2'b10) begin
            k = x * 8 / HA;
            return {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
        end
        if (x >= GX || y >= GY) return oreq ? orgb : 8'b000_001_00;
        if (md == 2'b00) begin
            if (x % (1 << (BPX + 4)) == 0) return 8'b000_000_11;
            if (x % (1 << (BPX + 3)) == 0) return 8'b000_000_01;
            if (x % (1 << BPX) == 0 || y % (1 << BPY) == 0) return 8'b111_000_00;
        end
        w = mem_arr[word_of(x, y)];
        b = DW - 1 - (x % PPW) / (1 << BPX);
        return w[b] ? 8'hFF : 8'b001_001_01;
    endfunction

    task automatic cycle();
        logic       r, oq;
        logic [1:0] md;
        logic [7:0] orgb, ec;
        logic       hs_e, vs_e, fs_e;
        int         h, v, d, pxh, pxv;
        @(posedge clk);
        r = rst; md = mode; oq = ovr_req; orgb = ovr_rgb;
        if (r) j = 0; else j++;
        pos_of(j, h, v);
        if (h < GX && v < GY) last_word = word_of(h, v);
        d = j - 1 - RL;
        if (r || d < 0) begin
            ec = 8'h00; hs_e = 1'b0; vs_e = 1'b0; fs_e = 1'b0;
        end else begin
            pos_of(d, h, v);
            ec   = exp_colour(h, v, md, oq, orgb);
            hs_e = (h >= HA + HFP) && (h < HA + HFP + HS);
            vs_e = (v >= VA + VFP) && (v < VA + VFP + VS);
            fs_e = (h == 0) && (v == 0) && (d % PD == 0);
        end
        if (r || j < RL) begin
            pxh = 0; pxv = 0;
        end else begin
            pos_of(j - RL, pxh, pxv);
        end
        @(negedge clk);
        check("rgb", 32'({red, green, blue}), 32'(ec));
        check("h_sync", 32'(h_sync), 32'(hs_e ^ SAL));
        check("v_sync", 32'(v_sync), 32'(vs_e ^ SAL));
        check("frame_start", 32'(frame_start), 32'(fs_e));
        check("pixel_x", 32'(pixel_x), 32'(pxh));
        check("pixel_y", 32'(pixel_y), 32'(pxv));
        check("mem_addr", 32'(mem_bus.mem_addr), 32'(last_word));
        if ($urandom_range(63) == 0) mode = 2'($urandom_range(3));
        ovr_req = 1'($urandom_range(1));
        ovr_rgb = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; ovr_req = 1'b0; ovr_rgb = 8'h00;
        for (int i = 0; i < (1 << AW); i++)
            mem_arr[i] = DW'($urandom);
        mem_arr[0] = 16'h8001;
        mem_arr[3] = 16'h0000;
        mem_arr[4] = 16'hFFFF;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2 * FRAME + 1000) cycle();
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (3000) cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
